// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and ALU-control signals around the ALU arbiter.
// a_lock/b_lock exist only when ALU_LOCK_EN is defined.
interface alu_arbiter_if #(parameter int DW = 8);
  logic          a_valid;
  logic [2:0]    a_cmd;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [2:0]    b_cmd;
  logic [DW-1:0] b_data;
  logic          b_ready;
`ifdef ALU_LOCK_EN
  logic          a_lock;
  logic          b_lock;
`endif
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_id;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_bus;
  logic          alu_wen;
  logic          alu_inc;
  logic          alu_rst;
  logic [DW-1:0] alu_dout;

  modport slave (
    input  a_valid, a_cmd, a_data, b_valid, b_cmd, b_data, resp_ready, alu_dout,
`ifdef ALU_LOCK_EN
    input  a_lock, b_lock,
`endif
    output a_ready, b_ready, resp_valid, resp_id, resp_data, resp_err,
    output alu_op, alu_bus, alu_wen, alu_inc, alu_rst
  );

  modport master (
    output a_valid, a_cmd, a_data, b_valid, b_cmd, b_data, resp_ready, alu_dout,
`ifdef ALU_LOCK_EN
    output a_lock, b_lock,
`endif
    input  a_ready, b_ready, resp_valid, resp_id, resp_data, resp_err,
    input  alu_op, alu_bus, alu_wen, alu_inc, alu_rst
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing the accumulator ALU between requesters A and B.
// Optional ALU_LOCK_EN lets a requester keep the grant across several commands.
`ifndef ALU_NONE
`define ALU_NONE 3'd0
`endif
`ifndef ALU_ADD
`define ALU_ADD 3'd1
`endif
`ifndef ALU_MUL
`define ALU_MUL 3'd2
`endif
`ifndef ALU_DIV
`define ALU_DIV 3'd3
`endif
`ifndef ALU_MOD
`define ALU_MOD 3'd4
`endif

module alu_arbiter #(
  parameter int DW = 8
) (
  input  logic        Clk,
  input  logic        RST,
  alu_arbiter_if.slave io
);

  localparam logic [2:0] CMD_LOAD = 3'd0;
  localparam logic [2:0] CMD_INC  = 3'd1;
  localparam logic [2:0] CMD_CLR  = 3'd2;
  localparam logic [2:0] CMD_ADD  = 3'd3;
  localparam logic [2:0] CMD_MUL  = 3'd4;
  localparam logic [2:0] CMD_DIV  = 3'd5;
  localparam logic [2:0] CMD_MOD  = 3'd6;
  localparam logic [2:0] CMD_READ = 3'd7;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state, state_nxt;
  logic [2:0]    cmd_q;
  logic [DW-1:0] data_q;
  logic          id_q;
  logic          err_q;
  logic          last_id;

  logic          grant_vld;
  logic          grant_id;
  logic [2:0]    grant_cmd;
  logic [DW-1:0] grant_data;
  logic          accept;
  logic          div_zero;

`ifdef ALU_LOCK_EN
  logic          lock_q;
  logic          lock_id_q;
`endif

  // A held lock restricts the grant to its owner; otherwise alternate on contention.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
`ifdef ALU_LOCK_EN
    if (lock_q) begin
      grant_id  = lock_id_q;
      grant_vld = lock_id_q ? io.b_valid : io.a_valid;
    end else
`endif
    if (io.a_valid && io.b_valid) begin
      grant_vld = 1'b1;
      grant_id  = ~last_id;
    end else begin
      grant_vld = io.a_valid | io.b_valid;
      grant_id  = io.b_valid;
    end
  end

  assign grant_cmd  = grant_id ? io.b_cmd  : io.a_cmd;
  assign grant_data = grant_id ? io.b_data : io.a_data;
  assign accept     = (state == IDLE) && grant_vld;
  assign div_zero   = ((grant_cmd == CMD_DIV) || (grant_cmd == CMD_MOD)) && (grant_data == '0);

  assign io.a_ready    = accept && !grant_id;
  assign io.b_ready    = accept && grant_id;
  assign io.resp_valid = (state == RESP);
  assign io.resp_id    = id_q;
  assign io.resp_err   = err_q;
  assign io.resp_data  = io.alu_dout;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (div_zero || (grant_cmd == CMD_READ)) state_nxt = RESP;
          else                                     state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = RESP;
      RESP:    if (io.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU controls are only non-idle during the single ISSUE cycle.
  always_comb begin
    io.alu_op  = `ALU_NONE;
    io.alu_bus = '0;
    io.alu_wen = 1'b0;
    io.alu_inc = 1'b0;
    io.alu_rst = 1'b0;
    if (state == ISSUE) begin
      case (cmd_q)
        CMD_LOAD: begin io.alu_wen = 1'b1; io.alu_bus = data_q; end
        CMD_INC:  io.alu_inc = 1'b1;
        CMD_CLR:  io.alu_rst = 1'b1;
        CMD_ADD:  begin io.alu_op = `ALU_ADD; io.alu_bus = data_q; end
        CMD_MUL:  begin io.alu_op = `ALU_MUL; io.alu_bus = data_q; end
        CMD_DIV:  begin io.alu_op = `ALU_DIV; io.alu_bus = data_q; end
        CMD_MOD:  begin io.alu_op = `ALU_MOD; io.alu_bus = data_q; end
        default:  ;
      endcase
    end
  end

  // last_id resets to B so that A wins the first contention.
  always_ff @(posedge Clk) begin
    if (RST) begin
      state   <= IDLE;
      cmd_q   <= '0;
      data_q  <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      last_id <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd_q   <= grant_cmd;
        data_q  <= grant_data;
        id_q    <= grant_id;
        err_q   <= div_zero;
        last_id <= grant_id;
      end
    end
  end

`ifdef ALU_LOCK_EN
  always_ff @(posedge Clk) begin
    if (RST) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else if ((state == RESP) && io.resp_ready) begin
      lock_q    <= id_q ? io.b_lock : io.a_lock;
      lock_id_q <= id_q;
    end
  end
`endif

endmodule
